exposure_controller: RTL and testbench
======================================

// Module: exposure_controller
// PURPOSE
//   Camera control FSM that sits directly upstream of the exposure timer counter.
//   Holds the user exposure setting and sequences erase -> expose -> readout.
//   Drives the timer with a start pulse and an exposure length.
//   Consumes the timer's overflow to end exposure, then runs the two-row readout.
// PARAMETERS
//   EXP_WIDTH    5   width of exposure setting / Timer_initial
//   EXP_MIN      2   lowest allowed exposure setting
//   EXP_MAX      30  highest allowed exposure setting (must be < 2**EXP_WIDTH-1)
//   EXP_DEFAULT  15  exposure setting after reset
//   WD_MARGIN    8   watchdog slack in cycles beyond Exp_time+1 (EXP_WATCHDOG_EN only)
// PORTS
//   Clk            in   1          clock, all logic on posedge
//   Reset          in   1          asynchronous, active-high reset
//   Init           in   1          start capture; level, sampled in IDLE only
//   Exp_increase   in   1          raise exposure by 1 per cycle asserted, IDLE only
//   Exp_decrease   in   1          lower exposure by 1 per cycle asserted, IDLE only
//   Ovf5           in   1          timer overflow; ends exposure
//   Timer_start    out  1          1-cycle pulse that restarts the timer
//   Timer_initial  out  EXP_WIDTH  exposure length to timer, latched at capture start
//   Erase          out  1          pixel erase, high in IDLE
//   Expose         out  1          pixel expose, high in EXPOSE
//   NRE_1          out  1          row-1 read enable, active-low
//   NRE_2          out  1          row-2 read enable, active-low
//   ADC            out  1          ADC sample strobe
//   Busy           out  1          high whenever state != IDLE
//   Timeout        out  1          sticky watchdog flag (EXP_WATCHDOG_EN only, else 0)
// BEHAVIOUR
//   Reset values (async, immediate)
//     state=IDLE, Exp_time=EXP_DEFAULT, Timer_initial=EXP_DEFAULT.
//     Erase=1; Expose=0, NRE_1=1, NRE_2=1, ADC=0, Timer_start=0, Busy=0, Timeout=0.
//   Exposure register (IDLE only)
//     inc && !dec && Exp_time<EXP_MAX -> +1.
//     dec && !inc && Exp_time>EXP_MIN -> -1.
//     Saturates at EXP_MIN/EXP_MAX; both asserted -> no change.
//     Init sampled high in the same cycle -> adjustment discarded (Init wins).
//     Inc/dec are ignored outside IDLE.
//   States
//     IDLE    Erase=1. Init=1 at edge -> EXPOSE; Timer_initial<=Exp_time at that edge.
//     EXPOSE  Erase=0, Expose=1.
//             Timer_start=1 in the first EXPOSE cycle only, 0 afterwards.
//             Ovf5 sampled high at edge -> READOUT, sub-counter rc<=0.
//             Ovf5 high in the first EXPOSE cycle (stale) is ignored.
//     READOUT Expose=0. rc runs 0..6, one step per cycle:
//             rc 0-2: NRE_1=0;  rc 1: ADC=1.
//             rc 3:   gap, all read outputs inactive.
//             rc 4-6: NRE_2=0;  rc 5: ADC=1.
//             At rc=6 edge -> IDLE.
//   Latency and edge cases
//     Init high at edge k -> Expose=1 and Timer_start=1 in cycle k+1.
//     Ovf5 high at edge n -> Expose=0 and NRE_1=0 in cycle n+1; readout is 7 cycles.
//     Init held high through readout -> next capture starts on the first IDLE edge
//       (IDLE lasts >= 1 cycle).
//     Init/Ovf5 outside their own state are ignored.
//     Timer_initial is stable for the whole capture.
//     Reset mid-capture -> IDLE with reset values on assertion; no partial readout.
// CONFIGURATION
//   EXP_WATCHDOG_EN defined
//     EXPOSE counts cycles.
//     If Exp_time+1+WD_MARGIN cycles pass without Ovf5 -> IDLE (readout skipped), Timeout<=1.
//     Timeout clears on the next accepted Init or on Reset.
//   EXP_WATCHDOG_EN undefined
//     No counter; EXPOSE waits for Ovf5 indefinitely; Timeout tied to 0.
// TESTING
//   1. Reset, 20 inc pulses -> Exp_time saturates at 30; 40 dec pulses -> 2; inc+dec together -> unchanged.
//   2. Exp_time=15, Init 1 cycle -> Timer_start 1 cycle, Timer_initial=15 held; Ovf5 after 16 cycles
//      -> Expose falls next cycle.
//   3. Readout check -> NRE_1 low 3 cycles, ADC at 2nd, 1 gap cycle, NRE_2 low 3 cycles, ADC at 2nd,
//      then Erase=1, Busy=0.
//   4. Inc, Init, stray Ovf5 during EXPOSE's first cycle and during READOUT -> no effect on
//      Exp_time/state/sequence.
//   5. Reset asserted at rc=2 and mid-EXPOSE -> all outputs at reset values immediately,
//      Exp_time=15.
//   6. EXP_WATCHDOG_EN, Exp_time=2, Ovf5 held 0 -> IDLE after 11 EXPOSE cycles, Timeout=1,
//      no NRE pulses; next Init clears Timeout.

Source files
------------

// File: rtl/exposure_controller.sv
// Exposure controller: holds the user exposure setting and sequences erase -> expose -> two-row readout.
// Optional EXPOSE watchdog is compiled in with `define EXP_WATCHDOG_EN.
module exposure_controller #(
    parameter int EXP_WIDTH   = 5,
    parameter int EXP_MIN     = 2,
    parameter int EXP_MAX     = 30,
    parameter int EXP_DEFAULT = 15,
    parameter int WD_MARGIN   = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Init,
    input  logic                 Exp_increase,
    input  logic                 Exp_decrease,
    input  logic                 Ovf5,
    output logic                 Timer_start,
    output logic [EXP_WIDTH-1:0] Timer_initial,
    output logic                 Erase,
    output logic                 Expose,
    output logic                 NRE_1,
    output logic                 NRE_2,
    output logic                 ADC,
    output logic                 Busy,
    output logic                 Timeout
);

    localparam logic [EXP_WIDTH-1:0] EXP_MIN_V     = EXP_WIDTH'(EXP_MIN);
    localparam logic [EXP_WIDTH-1:0] EXP_MAX_V     = EXP_WIDTH'(EXP_MAX);
    localparam logic [EXP_WIDTH-1:0] EXP_DEFAULT_V = EXP_WIDTH'(EXP_DEFAULT);
    localparam logic [2:0]           RC_LAST       = 3'd6;

    // The all-ones setting is reserved so the timer always has room to count.
    if (EXP_MAX >= (2 ** EXP_WIDTH) - 1 || EXP_MIN > EXP_DEFAULT ||
        EXP_DEFAULT > EXP_MAX || WD_MARGIN < 0) begin : g_bad_params
        $error("exposure_controller: inconsistent parameters");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXPOSE  = 2'd1,
        ST_READOUT = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [EXP_WIDTH-1:0] exp_time;
    logic [EXP_WIDTH-1:0] timer_initial_q;
    logic [2:0]           rc;
    logic                 first_cycle;
    logic                 ovf_accept;
    logic                 init_accept;

    assign init_accept   = (state == ST_IDLE) && Init;
    // An overflow seen in the first EXPOSE cycle belongs to the previous timer run.
    assign ovf_accept    = (state == ST_EXPOSE) && Ovf5 && !first_cycle;
    assign Timer_initial = timer_initial_q;

`ifdef EXP_WATCHDOG_EN
    localparam int WD_W = $clog2((2 ** EXP_WIDTH) + WD_MARGIN + 1);

    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_limit;
    logic            wd_expired;
    logic            timeout_q;

    // wd_cnt is 0 in the first EXPOSE cycle, so expiry lands after Exp_time+1+WD_MARGIN cycles.
    assign wd_limit   = WD_W'(timer_initial_q) + WD_W'(WD_MARGIN);
    assign wd_expired = (state == ST_EXPOSE) && !ovf_accept && (wd_cnt == wd_limit);
    assign Timeout    = timeout_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_EXPOSE) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (wd_expired) begin
                timeout_q <= 1'b1;
            end else if (init_accept) begin
                timeout_q <= 1'b0;
            end
        end
    end
`else
    logic wd_expired;

    assign wd_expired = 1'b0;
    assign Timeout    = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (Init) begin
                    state_next = ST_EXPOSE;
                end
            end
            ST_EXPOSE: begin
                if (ovf_accept) begin
                    state_next = ST_READOUT;
                end else if (wd_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_READOUT: begin
                if (rc == RC_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Erase       = 1'b0;
        Expose      = 1'b0;
        NRE_1       = 1'b1;
        NRE_2       = 1'b1;
        ADC         = 1'b0;
        Timer_start = 1'b0;
        Busy        = 1'b1;
        case (state)
            ST_IDLE: begin
                Erase = 1'b1;
                Busy  = 1'b0;
            end
            ST_EXPOSE: begin
                Expose      = 1'b1;
                Timer_start = first_cycle;
            end
            ST_READOUT: begin
                // rc 0-2 row 1, rc 3 settling gap, rc 4-6 row 2; ADC mid-row.
                NRE_1 = !(rc <= 3'd2);
                NRE_2 = !(rc >= 3'd4);
                ADC   = (rc == 3'd1) || (rc == 3'd5);
            end
            default: begin
                Erase = 1'b1;
                Busy  = 1'b0;
            end
        endcase
    end

    // Datapath: exposure setting, capture latch, readout sub-counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            exp_time        <= EXP_DEFAULT_V;
            timer_initial_q <= EXP_DEFAULT_V;
            rc              <= 3'd0;
            first_cycle     <= 1'b0;
        end else begin
            first_cycle <= init_accept;
            if (init_accept) begin
                timer_initial_q <= exp_time;
            end
            // Adjustment only in IDLE and only when no capture starts this edge.
            if ((state == ST_IDLE) && !Init) begin
                if (Exp_increase && !Exp_decrease && (exp_time < EXP_MAX_V)) begin
                    exp_time <= exp_time + EXP_WIDTH'(1);
                end else if (Exp_decrease && !Exp_increase && (exp_time > EXP_MIN_V)) begin
                    exp_time <= exp_time - EXP_WIDTH'(1);
                end
            end
            if ((state == ST_READOUT) && (rc != RC_LAST)) begin
                rc <= rc + 3'd1;
            end else begin
                rc <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_exposure_controller.sv
// Directed bench for exposure_controller: adjustment, capture timing, readout shape, stray inputs, reset.
// Build with `define EXP_WATCHDOG_EN to exercise the watchdog path.
module tb_exposure_controller;

    localparam int EW = 5;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Init;
    logic          Exp_increase;
    logic          Exp_decrease;
    logic          Ovf5;
    logic          Timer_start;
    logic [EW-1:0] Timer_initial;
    logic          Erase;
    logic          Expose;
    logic          NRE_1;
    logic          NRE_2;
    logic          ADC;
    logic          Busy;
    logic          Timeout;

    int checks = 0;
    int errors = 0;

    exposure_controller #(
        .EXP_WIDTH(EW), .EXP_MIN(2), .EXP_MAX(30), .EXP_DEFAULT(15), .WD_MARGIN(8)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Init(Init), .Exp_increase(Exp_increase),
        .Exp_decrease(Exp_decrease), .Ovf5(Ovf5), .Timer_start(Timer_start),
        .Timer_initial(Timer_initial), .Erase(Erase), .Expose(Expose), .NRE_1(NRE_1),
        .NRE_2(NRE_2), .ADC(ADC), .Busy(Busy), .Timeout(Timeout)
    );

    // Clock and global time bound
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time bound");
        $fatal(1, "time bound expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit order: Erase Expose NRE_1 NRE_2 ADC Timer_start Busy Timeout
    task automatic chk_outs(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, Erase, Expose, NRE_1, NRE_2, ADC, Timer_start, Busy, Timeout}, {24'd0, exp});
    endtask

    localparam logic [7:0] O_IDLE    = 8'b1011_0000;
    localparam logic [7:0] O_EXP_1ST = 8'b0111_0110;
    localparam logic [7:0] O_EXP     = 8'b0111_0010;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Called in the rc=0 cycle; leaves the bench in the first IDLE cycle afterwards.
    task automatic check_readout(input string tag);
        logic [7:0] exp_tab [7];
        exp_tab[0] = 8'b0001_0010;
        exp_tab[1] = 8'b0001_1010;
        exp_tab[2] = 8'b0001_0010;
        exp_tab[3] = 8'b0011_0010;
        exp_tab[4] = 8'b0010_0010;
        exp_tab[5] = 8'b0010_1010;
        exp_tab[6] = 8'b0010_0010;
        for (int i = 0; i < 7; i++) begin
            chk_outs($sformatf("%s_rc%0d", tag, i), exp_tab[i]);
            tick();
        end
        chk_outs({tag, "_idle"}, O_IDLE);
    endtask

    // Full capture from IDLE; Timer_initial must equal exp_ti.
    task automatic capture(input string tag, input logic [EW-1:0] exp_ti);
        Init = 1'b1;
        tick();
        Init = 1'b0;
        chk({tag, "_ti"}, {27'd0, Timer_initial}, {27'd0, exp_ti});
        chk_outs({tag, "_exp1"}, O_EXP_1ST);
        Ovf5 = 1'b1;
        tick();
        tick();
        Ovf5 = 1'b0;
        check_readout({tag, "_ro"});
    endtask

    initial begin
        Reset = 1'b1;
        Init = 1'b0;
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
        Ovf5 = 1'b0;
        #2;
        chk_outs("reset_outs", O_IDLE);
        chk("reset_ti", {27'd0, Timer_initial}, 32'd15);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        tick();
        chk_outs("idle_after_reset", O_IDLE);

        // Saturation at max, min, and inc+dec together
        Exp_increase = 1'b1;
        repeat (20) tick();
        Exp_increase = 1'b0;
        capture("sat_max", 5'd30);
        Exp_decrease = 1'b1;
        repeat (40) tick();
        Exp_decrease = 1'b0;
        capture("sat_min", 5'd2);
        Exp_increase = 1'b1;
        Exp_decrease = 1'b1;
        repeat (5) tick();
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
        capture("inc_dec_both", 5'd2);
        Exp_increase = 1'b1;
        repeat (13) tick();
        Exp_increase = 1'b0;

        // Exposure of 16 cycles at setting 15, then readout shape
        Init = 1'b1;
        tick();
        Init = 1'b0;
        chk_outs("exp15_first", O_EXP_1ST);
        chk("exp15_ti", {27'd0, Timer_initial}, 32'd15);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk_outs($sformatf("exp15_c%0d", i), O_EXP);
        end
        chk("exp15_ti_held", {27'd0, Timer_initial}, 32'd15);
        Ovf5 = 1'b1;
        tick();
        Ovf5 = 1'b0;
        chk("ro_ti_held", {27'd0, Timer_initial}, 32'd15);
        check_readout("ro15");

        // Stray inputs: Ovf5 in IDLE, inc with Init, stale Ovf5, everything held through readout
        Ovf5 = 1'b1;
        tick();
        chk_outs("ovf_in_idle", O_IDLE);
        Ovf5 = 1'b0;
        Init = 1'b1;
        Exp_increase = 1'b1;
        tick();
        chk_outs("stray_first", O_EXP_1ST);
        Ovf5 = 1'b1;
        tick();
        chk_outs("stale_ovf_ignored", O_EXP);
        Ovf5 = 1'b0;
        tick();
        chk_outs("stray_exp3", O_EXP);
        Ovf5 = 1'b1;
        tick();
        check_readout("stray_ro");
        tick();
        chk_outs("init_held_restart", O_EXP_1ST);
        chk("init_held_ti", {27'd0, Timer_initial}, 32'd15);
        Init = 1'b0;
        Exp_increase = 1'b0;
        tick();
        tick();
        Ovf5 = 1'b0;
        check_readout("stray_ro2");

        // Reset during readout at rc=2
        Exp_increase = 1'b1;
        repeat (2) tick();
        Exp_increase = 1'b0;
        Init = 1'b1;
        tick();
        Init = 1'b0;
        chk("pre_rst_ti", {27'd0, Timer_initial}, 32'd17);
        Ovf5 = 1'b1;
        tick();
        tick();
        Ovf5 = 1'b0;
        tick();
        tick();
        chk_outs("pre_rst_rc2", 8'b0001_0010);
        #2;
        Reset = 1'b1;
        #1;
        chk_outs("rst_ro_outs", O_IDLE);
        chk("rst_ro_ti", {27'd0, Timer_initial}, 32'd15);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        tick();
        chk_outs("rst_ro_no_partial", O_IDLE);
        capture("rst_ro_default", 5'd15);

        // Reset mid-EXPOSE
        Exp_increase = 1'b1;
        repeat (3) tick();
        Exp_increase = 1'b0;
        Init = 1'b1;
        tick();
        Init = 1'b0;
        chk("pre_rst2_ti", {27'd0, Timer_initial}, 32'd18);
        tick();
        tick();
        #2;
        Reset = 1'b1;
        #1;
        chk_outs("rst_exp_outs", O_IDLE);
        chk("rst_exp_ti", {27'd0, Timer_initial}, 32'd15);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        capture("rst_exp_default", 5'd15);

        // Missing overflow
        Exp_decrease = 1'b1;
        repeat (13) tick();
        Exp_decrease = 1'b0;
        Init = 1'b1;
        tick();
        Init = 1'b0;
        chk_outs("wd_first", O_EXP_1ST);
        chk("wd_ti", {27'd0, Timer_initial}, 32'd2);
`ifdef EXP_WATCHDOG_EN
        for (int i = 2; i <= 11; i++) begin
            tick();
            chk_outs($sformatf("wd_c%0d", i), O_EXP);
        end
        tick();
        chk_outs("wd_expired", O_IDLE | 8'b0000_0001);
        repeat (3) tick();
        chk_outs("wd_sticky_no_nre", O_IDLE | 8'b0000_0001);
        Init = 1'b1;
        tick();
        Init = 1'b0;
        chk_outs("wd_cleared", O_EXP_1ST);
        Ovf5 = 1'b1;
        tick();
        tick();
        Ovf5 = 1'b0;
        check_readout("wd_ro");
`else
        repeat (40) tick();
        chk_outs("no_wd_still_exposing", O_EXP);
        Ovf5 = 1'b1;
        tick();
        Ovf5 = 1'b0;
        check_readout("no_wd_ro");
`endif
        capture("final", 5'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
